// File: rtl/store_checkout_ctrl_pkg.sv
// store_pkg: shared types and constants for the checkout display controller.
//   state_t      - controller state encoding (IDLE, ADD, SHOW)
//   item_price() - 2-digit BCD price lookup by 3-bit item code
//   BLANK_*      - HEX blank masks for the total and item/price views
//   TOTAL_MAX    - saturation value of the 4-digit BCD total
package store_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [5:0]  BLANK_TOTAL = 6'b110000;
    localparam logic [5:0]  BLANK_SHOW  = 6'b011100;
    localparam logic [15:0] TOTAL_MAX   = 16'h9999;

    function automatic logic [7:0] item_price(input logic [2:0] item);
        logic [7:0] p;
        case (item)
            3'd0:    p = 8'h03;
            3'd1:    p = 8'h12;
            3'd2:    p = 8'h25;
            3'd3:    p = 8'h07;
            3'd4:    p = 8'h40;
            3'd5:    p = 8'h99;
            3'd6:    p = 8'h18;
            default: p = 8'h50;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/store_checkout_ctrl_if.sv
// store_checkout_if: button/selection inputs and display outputs of the
// checkout controller.
//   item_sel[2:0], add_btn, clr_btn : synchronised switch/button levels
//   digits[23:0]                    : six BCD codes, [23:20]=HEX5 .. [3:0]=HEX0
//   blank[5:0]                      : bit i blanks HEXi
//   busy, ovf                       : ADD/SHOW in progress, sticky saturation
// master drives the buttons (board/bench side), slave is the controller.
interface store_checkout_if;
    logic [2:0]  item_sel;
    logic        add_btn;
    logic        clr_btn;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic        busy;
    logic        ovf;

    modport master (
        output item_sel, add_btn, clr_btn,
        input  digits, blank, busy, ovf
    );

    modport slave (
        input  item_sel, add_btn, clr_btn,
        output digits, blank, busy, ovf
    );
endinterface

// File: rtl/store_checkout_ctrl_bcd_add4.sv
// bcd_add4: combinational 4-digit BCD + 2-digit BCD adder.
//   i_a[15:0] : 4-digit BCD augend
//   i_b[7:0]  : 2-digit BCD addend
//   o_sum     : 4-digit BCD sum (low four digits)
//   o_cout    : carry out of the thousands digit (true sum > 9999)
module bcd_add4 (
    input  logic [15:0] i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [15:0] w_b;
    logic [4:0]  w_c;

    assign w_b    = {8'h00, i_b};
    assign w_c[0] = 1'b0;

    // Per-digit binary add; a digit sum above 9 is pushed into the next
    // decade by adding 6, which also produces the decimal carry.
    for (genvar g = 0; g < 4; g++) begin : g_dig
        logic [4:0] w_raw;
        logic       w_adj;
        assign w_raw = {1'b0, i_a[4*g +: 4]} + {1'b0, w_b[4*g +: 4]} + {4'b0000, w_c[g]};
        assign w_adj = (w_raw > 5'd9);
        assign o_sum[4*g +: 4] = w_adj ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
        assign w_c[g+1] = w_adj;
    end

    assign o_cout = w_c[4];
endmodule

// File: rtl/store_checkout_ctrl.sv
// store_checkout_ctrl: checkout sequencer for the six-digit HEX display.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : store_checkout_if.slave (buttons in, BCD digits/blank/busy/ovf out)
// An add press runs one ADD cycle that updates the saturating BCD total,
// then SHOW holds the item/price view for HOLD_CYCLES cycles. IDLE shows
// the total. Display outputs decode registered state only.
module store_checkout_ctrl
    import store_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    store_checkout_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    state_t           r_state;
    logic [15:0]      r_total;
    logic             r_ovf;
    logic [2:0]       r_item;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_add_q;
    logic             r_clr_q;

    logic             w_add_rise;
    logic             w_clr_rise;
    logic [15:0]      w_sum;
    logic             w_cout;

    assign w_add_rise = bus.add_btn & ~r_add_q;
    assign w_clr_rise = bus.clr_btn & ~r_clr_q;

    bcd_add4 u_add (
        .i_a    (r_total),
        .i_b    (item_price(r_item)),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_total    <= 16'h0000;
            r_ovf      <= 1'b0;
            r_item     <= 3'd0;
            r_hold_cnt <= '0;
            // Treat buttons as already pressed so a level held across
            // reset release is not seen as a new press.
            r_add_q    <= 1'b1;
            r_clr_q    <= 1'b1;
        end else begin
            // Edge history tracks every cycle, so presses during ADD/SHOW
            // are consumed and never replay later.
            r_add_q <= bus.add_btn;
            r_clr_q <= bus.clr_btn;
            case (r_state)
                IDLE: begin
                    if (w_clr_rise) begin
                        r_total <= 16'h0000;
                        r_ovf   <= 1'b0;
                    end else if (w_add_rise) begin
                        r_item  <= bus.item_sel;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    if (w_cout) begin
                        r_total <= TOTAL_MAX;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_total <= w_sum;
                    end
                    r_hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
                    r_state    <= SHOW;
                end
                SHOW: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.digits = {8'h00, r_total};
        bus.blank  = BLANK_TOTAL;
        if (r_state == SHOW) begin
            bus.digits = {1'b0, r_item, 12'h000, item_price(r_item)};
            bus.blank  = BLANK_SHOW;
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_store_checkout_ctrl.sv
module tb_store_checkout_ctrl;
    import store_pkg::*;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    store_checkout_if bus();

    store_checkout_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  item;
        logic [7:0]  price;
        logic [15:0] total;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_total  = 0;
    bit   m_ovf    = 1'b0;
    int   PRICE [8] = '{3, 12, 25, 7, 40, 99, 18, 50};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] price_bcd(input int i);
        logic [15:0] t;
        t = to_bcd(PRICE[i]);
        return t[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One add press: push expectation, walk ADD and SHOW, check the result.
    // hold_btn keeps add_btn high afterwards; inject re-presses during SHOW.
    task automatic do_add(input logic [2:0] item, input bit hold_btn, input bit inject);
        exp_t        e;
        logic [15:0] old;
        int          n;
        old = to_bcd(m_total);
        m_total += PRICE[item];
        if (m_total > 9999) begin
            m_total = 9999;
            m_ovf   = 1'b1;
        end
        e.item  = item;
        e.price = price_bcd(item);
        e.total = to_bcd(m_total);
        e.ovf   = m_ovf;
        sb.push_back(e);

        bus.item_sel = item;
        bus.add_btn  = 1'b1;
        tick();
        if (!hold_btn) bus.add_btn = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.digits[15:0] !== old || bus.blank !== 6'b110000)
            $display("FAIL add_cycle: busy=%0b total=%h blank=%b, want busy=1 total=%h blank=110000",
                     bus.busy, bus.digits[15:0], bus.blank, old);
        else n_pass++;

        tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.digits !== {1'b0, e.item, 12'h000, e.price} || bus.blank !== 6'b011100 || bus.busy !== 1'b1)
            $display("FAIL show_view: digits=%h blank=%b busy=%0b, want digits=%h blank=011100 busy=1",
                     bus.digits, bus.blank, bus.busy, {1'b0, e.item, 12'h000, e.price});
        else n_pass++;
        n_checks++;
        if (bus.ovf !== e.ovf)
            $display("FAIL show_ovf: ovf=%0b, want %0b", bus.ovf, e.ovf);
        else n_pass++;

        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            if (inject) bus.add_btn = (n == 1);
            tick();
            n++;
        end
        if (!hold_btn) bus.add_btn = 1'b0;
        n_checks++;
        if (n !== HOLD)
            $display("FAIL show_len: cycles=%0d, want %0d", n, HOLD);
        else n_pass++;
        n_checks++;
        if (bus.digits !== {8'h00, e.total} || bus.blank !== 6'b110000 || bus.ovf !== e.ovf)
            $display("FAIL idle_total: digits=%h blank=%b ovf=%0b, want digits=%h blank=110000 ovf=%0b",
                     bus.digits, bus.blank, bus.ovf, {8'h00, e.total}, e.ovf);
        else n_pass++;
    endtask

    task automatic do_clear();
        bus.clr_btn = 1'b1;
        tick();
        bus.clr_btn = 1'b0;
        m_total = 0;
        m_ovf   = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 24'h000000 || bus.ovf !== 1'b0)
            $display("FAIL clear: busy=%0b digits=%h ovf=%0b, want 0/000000/0", bus.busy, bus.digits, bus.ovf);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.item_sel = 3'd0;
        bus.add_btn  = 1'b0;
        bus.clr_btn  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.digits !== 24'h000000 || bus.blank !== 6'b110000 || bus.busy !== 1'b0 || bus.ovf !== 1'b0)
            $display("FAIL reset: digits=%h blank=%b busy=%0b ovf=%0b, want 000000/110000/0/0",
                     bus.digits, bus.blank, bus.busy, bus.ovf);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_add();
        do_add(3'd2, 1'b0, 1'b0);
        n_checks++;
        if (bus.digits[15:0] !== 16'h0025)
            $display("FAIL single_add: total=%h, want 0025", bus.digits[15:0]);
        else n_pass++;
    endtask

    task automatic test_held_button();
        do_clear();
        do_add(3'd1, 1'b1, 1'b0);
        // keep the button high well past SHOW; no further add may start
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (bus.busy !== 1'b0)
                $display("FAIL held_no_refire: busy=%0b at cycle %0d, want 0", bus.busy, i);
            else n_pass++;
        end
        bus.add_btn = 1'b0;
        tick();
        do_add(3'd1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits[15:0] !== 16'h0024)
            $display("FAIL show_press_dropped: busy=%0b total=%h, want 0 0024", bus.busy, bus.digits[15:0]);
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_clear();
        for (int i = 0; i < 101; i++) do_add(3'd5, 1'b0, 1'b0);
        n_checks++;
        if (bus.digits[15:0] !== 16'h9999 || bus.ovf !== 1'b0)
            $display("FAIL exact_9999: total=%h ovf=%0b, want 9999 0", bus.digits[15:0], bus.ovf);
        else n_pass++;
        do_add(3'd5, 1'b0, 1'b0);
        n_checks++;
        if (bus.digits[15:0] !== 16'h9999 || bus.ovf !== 1'b1)
            $display("FAIL saturate: total=%h ovf=%0b, want 9999 1", bus.digits[15:0], bus.ovf);
        else n_pass++;
        do_add(3'd0, 1'b0, 1'b0);
        n_checks++;
        if (bus.digits[15:0] !== 16'h9999 || bus.ovf !== 1'b1)
            $display("FAIL sticky_ovf: total=%h ovf=%0b, want 9999 1", bus.digits[15:0], bus.ovf);
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        do_clear();
        do_add(3'd2, 1'b0, 1'b0);
        bus.item_sel = 3'd4;
        bus.add_btn  = 1'b1;
        bus.clr_btn  = 1'b1;
        tick();
        bus.add_btn = 1'b0;
        bus.clr_btn = 1'b0;
        m_total = 0;
        m_ovf   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.busy !== 1'b0 || bus.digits !== 24'h000000 || bus.ovf !== 1'b0)
                $display("FAIL clr_priority: busy=%0b digits=%h ovf=%0b, want 0/000000/0",
                         bus.busy, bus.digits, bus.ovf);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid_show();
        do_add(3'd6, 1'b0, 1'b0);
        bus.item_sel = 3'd3;
        bus.add_btn  = 1'b1;
        tick();
        bus.add_btn = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.blank !== 6'b011100)
            $display("FAIL pre_reset_show: busy=%0b blank=%b, want 1 011100", bus.busy, bus.blank);
        else n_pass++;
        rst_n = 1'b0;
        bus.add_btn = 1'b1;
        tick();
        m_total = 0;
        m_ovf   = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 24'h000000 || bus.blank !== 6'b110000 || bus.ovf !== 1'b0)
            $display("FAIL reset_mid_show: busy=%0b digits=%h blank=%b ovf=%0b, want 0/000000/110000/0",
                     bus.busy, bus.digits, bus.blank, bus.ovf);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.busy !== 1'b0 || bus.digits !== 24'h000000)
                $display("FAIL held_through_reset: busy=%0b digits=%h, want 0 000000", bus.busy, bus.digits);
            else n_pass++;
        end
        bus.add_btn = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_held_button();
        test_saturate();
        test_clear_priority();
        test_reset_mid_show();
        n_checks++;
        if (sb.size() !== 0)
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
